// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the Mini-MIPS core.
// Owns the fetch PC, issues one instruction-memory request at a time, waits
// for the read data and holds the fetched instruction until decode takes it.
// Branch/jump redirects from execute override every other event in the cycle.
//
// Handshakes:
//   imem side: imem_req is held high in REQ until imem_gnt is seen on a rising
//     edge. Exactly one imem_rvalid pulse returns per granted request.
//   decode side: inst_valid/inst/inst_pc stay stable until a hand-off, which is
//     a rising edge with inst_valid & inst_ready & ~stall all high.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          PC_STEP     = 4,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic          discard_q, discard_d;
  logic          fetch_err_q, fetch_err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [31:0]   redir_pc;
  logic          handoff;

  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign handoff  = (state_q == S_HOLD) & inst_ready & ~stall;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      discard_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      discard_q   <= discard_d;
      fetch_err_q <= fetch_err_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state logic; a redirect is checked first in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    discard_d   = discard_q;
    timer_d     = timer_q;
    fetch_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redir_pc;
        else if (run)       state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_gnt) begin
          state_d   = S_WAIT;
          timer_d   = '0;
          // A redirect racing the grant makes the in-flight data stale.
          discard_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + TW'(1);
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 32'(PC_STEP);
            state_d   = S_HOLD;
          end
        end else if (timer_q >= TIMER_LAST) begin
          // >= so a redirect landing on the last cycle still times out next cycle.
          fetch_err_d = 1'b1;
          discard_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_HOLD: begin
        if (redirect_valid) pc_d = redir_pc;
        // Hand-off delivers; a redirect without hand-off squashes. Both leave HOLD.
        if (handoff || redirect_valid) state_d = run ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    imem_req   = (state_q == S_REQ);
    imem_addr  = pc_q;
    inst_valid = (state_q == S_HOLD);
    inst       = inst_q;
    inst_pc    = inst_pc_q;
    pc         = pc_q;
    fetch_err  = fetch_err_q;
    dbg_state  = state_q;
  end

endmodule
